// File: rtl/seg_adder.sv
// -----------------------------------------------------------------------------
// seg_adder
//
// Multi-cycle segmented adder/subtractor. A WIDTH-bit operation is processed
// CHUNK bits per clock through one narrow carry chain. The block takes
// N = WIDTH/CHUNK cycles per operation. It uses a valid/ready handshake on
// both the operand side and the result side.
//
// WIDTH must be an integer multiple of CHUNK.
//
// Optional feature:
//   SEG_ADDER_OVF_EN  When defined, ovf reports signed overflow. It is the
//                     carry into the MSB XOR the carry out of the MSB, and it
//                     is captured with cout on the final segment. When
//                     undefined, ovf is tied to 0 and the MSB carry tap is
//                     not built.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand request
//   in_ready   operands can be accepted (IDLE only)
//   a, b       WIDTH-bit operands
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0: a+b+cin, 1: a-b-cin
//   out_valid  result available (DONE only)
//   out_ready  consumer takes the result
//   sum        result modulo 2^WIDTH, meaningful while out_valid=1
//   cout       raw carry out of the MSB (for sub, 1 means no borrow)
//   ovf        signed overflow, or 0 when the feature is disabled
//   busy       an operation is in flight or waiting to be consumed
// -----------------------------------------------------------------------------
module seg_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int N     = WIDTH / CHUNK;
  localparam int SEG_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SEG_W-1:0]   seg_q;
  logic               carry_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;

  logic               accept;
  logic               run;
  logic               last;
  int                 base;
  logic [CHUNK-1:0]   a_seg, b_seg;
  logic [CHUNK:0]     seg_res;

  // One CHUNK-wide add with carry. Bit CHUNK of the result is the carry out.
  function automatic logic [CHUNK:0] seg_add(input logic [CHUNK-1:0] x,
                                             input logic [CHUNK-1:0] y,
                                             input logic             c);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
  endfunction

  // FSM next state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (seg_q == SEG_LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = (state_q == IDLE) && in_valid;
  assign run    = (state_q == RUN);
  assign last   = (seg_q == SEG_LAST);

  // Select the current segment of each latched operand
  always_comb begin
    base    = int'(seg_q) * CHUNK;
    a_seg   = a_q[base +: CHUNK];
    b_seg   = b_q[base +: CHUNK];
    seg_res = seg_add(a_seg, b_seg, carry_q);
  end

  // Operand capture. For subtraction b is stored inverted, so RUN always adds.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= sub ? ~b : b;
    end
  end

  // State, segment counter, carry chain and result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      seg_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        // For subtraction a + ~b + 1 - cin = a - b - cin
        carry_q <= cin ^ sub;
        seg_q   <= '0;
      end else if (run) begin
        sum_q[base +: CHUNK] <= seg_res[CHUNK-1:0];
        carry_q              <= seg_res[CHUNK];
        seg_q                <= last ? '0 : seg_q + SEG_W'(1);
        if (last) cout_q <= seg_res[CHUNK];
      end
    end
  end

`ifdef SEG_ADDER_OVF_EN
  logic ovf_q;
  logic msb_cin;

  // Recover the carry into the MSB from the MSB sum bit: s = a ^ b ^ c_in
  assign msb_cin = a_seg[CHUNK-1] ^ b_seg[CHUNK-1] ^ seg_res[CHUNK-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (run && last) begin
      ovf_q <= msb_cin ^ seg_res[CHUNK];
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
